// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with a start/done handshake, remainder output,
// divide-by-zero flag and an optional two's-complement mode.
module seq_divider #(
    parameter int M      = 26,
    parameter int N      = 14,
    parameter bit SIGNED = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero
);
    localparam int CW = $clog2(M + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_reg;
    logic [M-1:0]  dvd_reg;     // dividend bits shift out of the top, quotient bits in at the bottom
    logic [N-1:0]  dvs_reg;
    logic [N:0]    pr_reg;
    logic [CW-1:0] cnt_reg;
    logic          sign_q_reg;
    logic          sign_r_reg;
    logic          zero_reg;

    logic          dvd_neg;
    logic          dvs_neg;
    logic [M-1:0]  dvd_mag;
    logic [N-1:0]  dvs_mag;
    logic [N:0]    shifted;
    logic [N:0]    trial;
    logic          fits;
    logic [M-1:0]  q_final;
    logic [N-1:0]  r_final;

    always_comb begin
        dvd_neg = SIGNED && dividend[M-1];
        dvs_neg = SIGNED && divisor[N-1];
        // The most-negative value negates to itself, which is the correct unsigned magnitude.
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor : divisor;
        shifted = {pr_reg[N-1:0], dvd_reg[M-1]};
        fits    = shifted >= {1'b0, dvs_reg};
        trial   = shifted - {1'b0, dvs_reg};
        q_final = (SIGNED && sign_q_reg) ? -dvd_reg : dvd_reg;
        r_final = (SIGNED && sign_r_reg) ? -pr_reg[N-1:0] : pr_reg[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            pr_reg     <= '0;
            cnt_reg    <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            zero_reg   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            quotient   <= '0;
            remainder  <= '0;
            div_zero   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sign_q_reg <= dvd_neg ^ dvs_neg;
                        sign_r_reg <= dvd_neg;
                        dvs_reg    <= dvs_mag;
                        pr_reg     <= '0;
                        cnt_reg    <= CW'(M);
                        if (divisor == '0) begin
                            // Raw dividend is kept so its low bits can be reported as the remainder.
                            zero_reg  <= 1'b1;
                            dvd_reg   <= dividend;
                            busy      <= 1'b0;
                            state_reg <= DONE;
                        end else begin
                            zero_reg  <= 1'b0;
                            dvd_reg   <= dvd_mag;
                            busy      <= 1'b1;
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    pr_reg  <= fits ? trial : shifted;
                    dvd_reg <= {dvd_reg[M-2:0], fits};
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    quotient  <= zero_reg ? '1 : q_final;
                    remainder <= zero_reg ? dvd_reg[N-1:0] : r_final;
                    div_zero  <= zero_reg;
                    done      <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: four instances (26/14 and 8/8, unsigned and signed) checked against
// a plain-arithmetic reference model with directed cases and a randomised sweep.
module tb_seq_divider;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  start;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [3:0]  dz_v;
    logic [25:0] a0, a1, q0, q1;
    logic [13:0] b0, b1, r0, r1;
    logic [7:0]  a2, a3, b2, b3, q2, q3, r2, r3;

    int vec_count   = 0;
    int miscompares = 0;

    logic [63:0] oq, orr, oz, od, ob;

    seq_divider #(.M(26), .N(14), .SIGNED(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .dividend(a0), .divisor(b0),
        .busy(busy_v[0]), .done(done_v[0]), .quotient(q0), .remainder(r0), .div_zero(dz_v[0]));
    seq_divider #(.M(26), .N(14), .SIGNED(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .dividend(a1), .divisor(b1),
        .busy(busy_v[1]), .done(done_v[1]), .quotient(q1), .remainder(r1), .div_zero(dz_v[1]));
    seq_divider #(.M(8), .N(8), .SIGNED(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .dividend(a2), .divisor(b2),
        .busy(busy_v[2]), .done(done_v[2]), .quotient(q2), .remainder(r2), .div_zero(dz_v[2]));
    seq_divider #(.M(8), .N(8), .SIGNED(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .dividend(a3), .divisor(b3),
        .busy(busy_v[3]), .done(done_v[3]), .quotient(q3), .remainder(r3), .div_zero(dz_v[3]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int inst, input logic [63:0] a, input logic [63:0] b);
        case (inst)
            0: begin a0 = a[25:0]; b0 = b[13:0]; end
            1: begin a1 = a[25:0]; b1 = b[13:0]; end
            2: begin a2 = a[7:0];  b2 = b[7:0];  end
            default: begin a3 = a[7:0]; b3 = b[7:0]; end
        endcase
    endtask

    task automatic sample(input int inst);
        case (inst)
            0: begin oq = 64'(q0); orr = 64'(r0); end
            1: begin oq = 64'(q1); orr = 64'(r1); end
            2: begin oq = 64'(q2); orr = 64'(r2); end
            default: begin oq = 64'(q3); orr = 64'(r3); end
        endcase
        oz = 64'(dz_v[inst]);
        od = 64'(done_v[inst]);
        ob = 64'(busy_v[inst]);
    endtask

    function automatic int width_m(input int inst);
        return (inst < 2) ? 26 : 8;
    endfunction

    // Reference: Verilog integer division truncates toward zero and % follows the dividend's sign.
    function automatic void model(input int inst, input logic [63:0] a_in, input logic [63:0] b_in,
                                  output logic [63:0] eq, output logic [63:0] er,
                                  output logic [63:0] ez, output int elat);
        int m, n;
        logic [63:0] mm, nm, a, b;
        longint sa, sb;
        m  = width_m(inst);
        n  = (inst < 2) ? 14 : 8;
        mm = (64'd1 << m) - 64'd1;
        nm = (64'd1 << n) - 64'd1;
        a  = a_in & mm;
        b  = b_in & nm;
        if (b == 64'd0) begin
            eq = mm; er = a & nm; ez = 64'd1; elat = 1;
        end else begin
            ez = 64'd0; elat = m + 1;
            if (inst % 2 == 0) begin
                eq = a / b; er = a % b;
            end else begin
                sa = longint'(a); sb = longint'(b);
                if (a[m-1]) sa = sa - (longint'(1) << m);
                if (b[n-1]) sb = sb - (longint'(1) << n);
                eq = 64'(sa / sb) & mm;
                er = 64'(sa % sb) & nm;
            end
        end
    endfunction

    task automatic run_op(input int inst, input logic [63:0] a, input logic [63:0] b,
                          input string tag, output logic [63:0] rq, output logic [63:0] rr);
        logic [63:0] eq, er, ez;
        int elat, lat, bcnt, both;
        model(inst, a, b, eq, er, ez, elat);
        @(negedge clk);
        drive(inst, a, b);
        start[inst] = 1'b1;
        @(posedge clk);
        #1;
        start[inst] = 1'b0;
        lat = 0; both = 0;
        sample(inst);
        bcnt = (ob === 64'd1) ? 1 : 0;
        while (od !== 64'd1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            sample(inst);
            if (ob === 64'd1) bcnt++;
            if (ob === 64'd1 && od === 64'd1) both = 1;
        end
        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " quotient"}, oq, eq);
        check({tag, " remainder"}, orr, er);
        check({tag, " div_zero"}, oz, ez);
        check({tag, " busy_cycles"}, 64'(bcnt), (elat == 1) ? 64'd0 : 64'(width_m(inst)));
        check({tag, " busy_with_done"}, 64'(both), 64'd0);
        rq = oq; rr = orr;
        @(posedge clk);
        #1;
        sample(inst);
        check({tag, " done_one_cycle"}, od, 64'd0);
        check({tag, " hold_q"}, oq, eq);
    endtask

    initial begin
        logic [63:0] rq, rr, ra, rb;
        int ndone, dlat, sel, inst;
        logic [63:0] dq, dr;

        rst_n = 1'b0; start = '0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0; b0 = '0; b1 = '0; b2 = '0; b3 = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            sample(i);
            check("reset done", od, 64'd0);
            check("reset busy", ob, 64'd0);
            check("reset quotient", oq, 64'd0);
            check("reset remainder", orr, 64'd0);
            check("reset div_zero", oz, 64'd0);
        end
        rst_n = 1'b1;

        run_op(0, 64'h2758000, 64'h0B4B, "q14 scale", rq, rr);
        check("q14 scale literal q", rq, 64'd14270);
        check("q14 scale literal r", rr, 64'd342);
        run_op(0, 64'h2758000, 64'd0, "div0", rq, rr);
        check("div0 literal q", rq, 64'h3FFFFFF);
        check("div0 literal r", rr, 64'd0);
        run_op(0, 64'd100, 64'd7, "after div0", rq, rr);
        check("after div0 literal q", rq, 64'd14);

        run_op(1, 64'(-100), 64'd7, "s -100/7", rq, rr);
        check("s -100/7 literal q", rq, 64'(-14) & 64'h3FFFFFF);
        check("s -100/7 literal r", rr, 64'(-2) & 64'h3FFF);
        run_op(1, 64'd100, 64'(-7), "s 100/-7", rq, rr);
        check("s 100/-7 literal r", rr, 64'd2);
        run_op(1, 64'(-100), 64'(-7), "s -100/-7", rq, rr);
        check("s -100/-7 literal q", rq, 64'd14);
        run_op(1, 64'h2000000, 64'(-1), "s mostneg/-1", rq, rr);
        check("s mostneg/-1 literal q", rq, 64'h2000000);
        check("s mostneg/-1 literal r", rr, 64'd0);

        // start pulses while busy must be ignored
        @(negedge clk);
        drive(0, 64'd100, 64'd7);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        ndone = 0; dlat = 0; dq = '0; dr = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            start[0] = 1'b0;
            sample(0);
            if (od === 64'd1) begin ndone++; dlat = c; dq = oq; dr = orr; end
            if (c == 4 || c == 19) begin
                drive(0, 64'd55, 64'd3);
                start[0] = 1'b1;
            end
        end
        check("ignore start done_count", 64'(ndone), 64'd1);
        check("ignore start latency", 64'(dlat), 64'd27);
        check("ignore start q", dq, 64'd14);
        check("ignore start r", dr, 64'd2);

        // start held high through the done cycle; operand changes after acceptance are ignored
        @(negedge clk);
        drive(0, 64'd100, 64'd7);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 64'd1000, 64'd3);
        dlat = 0;
        sample(0);
        while (od !== 64'd1 && dlat < 100) begin @(posedge clk); #1; dlat++; sample(0); end
        check("held start first latency", 64'(dlat), 64'd27);
        check("held start first q", oq, 64'd14);
        check("held start first r", orr, 64'd2);
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        dlat = 0;
        sample(0);
        while (od !== 64'd1 && dlat < 100) begin @(posedge clk); #1; dlat++; sample(0); end
        check("held start second latency", 64'(dlat), 64'd27);
        check("held start second q", oq, 64'd333);
        check("held start second r", orr, 64'd1);
        @(posedge clk);
        #1;

        // reset in the middle of an operation
        @(negedge clk);
        drive(0, 64'd100, 64'd7);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            sample(0);
            if (od === 64'd1) ndone++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sample(0);
        if (od === 64'd1) ndone++;
        check("midreset no done", 64'(ndone), 64'd0);
        check("midreset busy", ob, 64'd0);
        check("midreset quotient", oq, 64'd0);
        check("midreset remainder", orr, 64'd0);
        check("midreset div_zero", oz, 64'd0);
        rst_n = 1'b1;
        run_op(0, 64'd1000, 64'd3, "after reset", rq, rr);
        check("after reset literal q", rq, 64'd333);
        check("after reset literal r", rr, 64'd1);

        // randomised sweep over all four configurations
        for (int i = 0; i < 1000; i++) begin
            inst = i % 4;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            sel = $urandom_range(0, 15);
            if (sel == 0) rb = 64'd0;
            else if (sel == 1) begin
                rb = '1;
                ra = 64'd1 << (width_m(inst) - 1);
            end else if (sel == 2) rb = 64'd1;
            else if (sel < 6) rb = rb & 64'h1F;
            run_op(inst, ra, rb, $sformatf("rand%0d inst%0d", i, inst), rq, rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
